// File: rtl/lvds_sync_if.sv
// Marker inputs and recovered-sync outputs of the LVDS sync receiver.
// The master drives the markers; the slave (receiver) drives the status.
interface lvds_sync_if #(
    parameter int AW = 11
);
    logic          lsync_in;
    logic          fsync_in;
    logic [AW-1:0] rx_col;
    logic [AW-1:0] rx_row;
    logic          sol;
    logic          sof;
    logic          locked;
    logic          line_err;
    logic          frame_err;
    logic [15:0]   err_cnt;

    modport master (
        output lsync_in, fsync_in,
        input  rx_col, rx_row, sol, sof, locked,
        input  line_err, frame_err, err_cnt
    );

    modport slave (
        input  lsync_in, fsync_in,
        output rx_col, rx_row, sol, sof, locked,
        output line_err, frame_err, err_cnt
    );
endinterface

// File: rtl/lvds_sync_rx.sv
// Flywheel sync recovery for the camera LVDS link: predicts column/row,
// checks line/frame markers, and tracks lock via HUNT/VERIFY/LOCKED.
module lvds_sync_rx #(
    parameter int H_TOTAL    = 1064,
    parameter int V_TOTAL    = 1028,
    parameter int AW         = 11,
    parameter int LOCK_CNT   = 2,
    parameter int UNLOCK_CNT = 3
) (
    input  logic        clk,
    input  logic        rst,
    lvds_sync_if.slave  bus
);
    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int BW = $clog2(UNLOCK_CNT + 1);
    localparam logic [AW-1:0] H_LAST = AW'(H_TOTAL - 1);
    localparam logic [AW-1:0] H_RLD  = AW'(H_TOTAL - 2);
    localparam logic [AW-1:0] V_LAST = AW'(V_TOTAL - 1);

    typedef enum logic [1:0] {
        HUNT,
        VERIFY,
        LOCKED
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] pcol_q, pcol_d;
    logic [AW-1:0] prow_q, prow_d;
    logic [GW-1:0] good_q, good_d;
    logic [BW-1:0] bad_q, bad_d;
    logic          fbad_q, fbad_d;
    logic [AW-1:0] rx_col_q, rx_row_q;
    logic          sol_q, sof_q;
    logic          line_err_q, frame_err_q;
    logic [15:0]   err_cnt_q;

    logic          at_sol, at_sof, boundary;
    logic          chk, lmis, fmis, mis;
    logic          reload;
    logic [GW-1:0] good_inc;
    logic [BW-1:0] bad_inc;

    assign at_sol   = (pcol_q == H_LAST);
    assign at_sof   = at_sol && (prow_q == V_LAST);
    assign boundary = (pcol_q == '0) && (prow_q == '0);
    assign chk      = (state_q != HUNT);
    assign lmis     = chk && (bus.lsync_in ^ at_sol);
    assign fmis     = chk && (bus.fsync_in ^ at_sof);
    assign mis      = lmis || fmis;
    assign good_inc = good_q + GW'(1);
    assign bad_inc  = bad_q + BW'(1);

    // Lock FSM next state, frame health counters and predictor reload.
    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        bad_d   = bad_q;
        fbad_d  = boundary ? 1'b0 : (fbad_q || mis);
        reload  = 1'b0;
        unique case (state_q)
            HUNT: begin
                if (bus.fsync_in) begin
                    reload  = 1'b1;
                    good_d  = '0;
                    fbad_d  = 1'b0;
                    state_d = VERIFY;
                end
            end
            VERIFY: begin
                if (mis) begin
                    if (bus.fsync_in) begin
                        reload = 1'b1;
                        good_d = '0;
                        fbad_d = 1'b0;
                    end else begin
                        state_d = HUNT;
                    end
                end else if (boundary && !fbad_q) begin
                    good_d = good_inc;
                    if (good_inc == GW'(LOCK_CNT)) begin
                        state_d = LOCKED;
                        bad_d   = '0;
                    end
                end
            end
            LOCKED: begin
                if (boundary) begin
                    if (fbad_q || mis) begin
                        bad_d = bad_inc;
                        if (bad_inc == BW'(UNLOCK_CNT)) begin
                            state_d = HUNT;
                        end
                    end else begin
                        bad_d = '0;
                    end
                end
            end
            default: state_d = HUNT;
        endcase
    end

    // Flywheel: count down, or realign to the marker after a reload.
    always_comb begin
        pcol_d = pcol_q - AW'(1);
        prow_d = prow_q;
        if (reload) begin
            pcol_d = H_RLD;
            prow_d = V_LAST;
        end else if (pcol_q == '0) begin
            pcol_d = H_LAST;
            prow_d = (prow_q == '0) ? V_LAST : prow_q - AW'(1);
        end
    end

    // State, predictor and frame-health registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HUNT;
            pcol_q  <= '0;
            prow_q  <= '0;
            good_q  <= '0;
            bad_q   <= '0;
            fbad_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pcol_q  <= pcol_d;
            prow_q  <= prow_d;
            good_q  <= good_d;
            bad_q   <= bad_d;
            fbad_q  <= fbad_d;
        end
    end

    // Registered position, sync pulses and mismatch pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_col_q    <= '0;
            rx_row_q    <= '0;
            sol_q       <= 1'b0;
            sof_q       <= 1'b0;
            line_err_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_col_q    <= pcol_q;
            rx_row_q    <= prow_q;
            sol_q       <= at_sol && (state_q == LOCKED);
            sof_q       <= at_sof && (state_q == LOCKED);
            line_err_q  <= lmis;
            frame_err_q <= fmis;
        end
    end

    // Saturating count of cycles with any marker mismatch.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else if (mis && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign bus.rx_col    = rx_col_q;
    assign bus.rx_row    = rx_row_q;
    assign bus.sol       = sol_q;
    assign bus.sof       = sof_q;
    assign bus.locked    = (state_q == LOCKED);
    assign bus.line_err  = line_err_q;
    assign bus.frame_err = frame_err_q;
    assign bus.err_cnt   = err_cnt_q;
endmodule

// File: tb/tb_lvds_sync_rx.sv
// Directed bench for lvds_sync_rx using a reduced 8x4 frame geometry.
// A second instance with a large unlock threshold exercises err_cnt saturation.
module tb_lvds_sync_rx;
    localparam int H  = 8;
    localparam int V  = 4;
    localparam int AW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lvds_sync_if #(.AW(AW)) bus ();
    lvds_sync_if #(.AW(AW)) bus2 ();

    lvds_sync_rx #(
        .H_TOTAL(H), .V_TOTAL(V), .AW(AW),
        .LOCK_CNT(2), .UNLOCK_CNT(3)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    lvds_sync_rx #(
        .H_TOTAL(H), .V_TOTAL(V), .AW(AW),
        .LOCK_CNT(2), .UNLOCK_CNT(4095)
    ) dut2 (
        .clk(clk), .rst(rst), .bus(bus2)
    );

    int errors = 0;
    int checks = 0;
    int cc = 0;
    int cr = 0;
    int tick = 0;
    bit sat = 1'b0;

    task automatic cyc(input logic l, input logic f);
        bus.lsync_in  = l;
        bus.fsync_in  = f;
        bus2.lsync_in = sat ? 1'b1 : l;
        bus2.fsync_in = sat ? 1'b1 : f;
        @(posedge clk);
        #1;
        tick++;
    endtask

    // One camera sample: dl drops lsync, df drops fsync, xl adds an lsync.
    task automatic cam1(input bit dl, input bit df, input bit xl);
        logic l, f;
        l = ((cc == H - 1) && !dl) || xl;
        f = (cc == H - 1) && (cr == V - 1) && !df;
        cyc(l, f);
        if (cc == 0) begin
            cc = H - 1;
            cr = (cr == 0) ? V - 1 : cr - 1;
        end else begin
            cc = cc - 1;
        end
    endtask

    task automatic run_to(input int c, input int r);
        int n = 0;
        while (!(cc == c && cr == r) && n < 64) begin
            cam1(0, 0, 0);
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc(0, 0);
        cyc(0, 0);
        checks++;
        if (bus.rx_col !== 4'd0) begin
            errors++;
            $display("FAIL rst_rx_col got %0d want 0", bus.rx_col);
        end
        checks++;
        if (bus.rx_row !== 4'd0) begin
            errors++;
            $display("FAIL rst_rx_row got %0d want 0", bus.rx_row);
        end
        checks++;
        if ({bus.sol, bus.sof} !== 2'b00) begin
            errors++;
            $display("FAIL rst_sol_sof got %b want 00", {bus.sol, bus.sof});
        end
        checks++;
        if (bus.locked !== 1'b0) begin
            errors++;
            $display("FAIL rst_locked got %b want 0", bus.locked);
        end
        checks++;
        if ({bus.line_err, bus.frame_err} !== 2'b00) begin
            errors++;
            $display("FAIL rst_errs got %b want 00",
                     {bus.line_err, bus.frame_err});
        end
        checks++;
        if (bus.err_cnt !== 16'd0) begin
            errors++;
            $display("FAIL rst_err_cnt got %0d want 0", bus.err_cnt);
        end
        rst = 1'b0;
    endtask

    task automatic test_lock();
        bit seen = 1'b0;
        int nsol = 0;
        int nsof = 0;
        int sof_t0 = -1;
        int sof_t1 = -1;
        bit posbad = 1'b0;
        int ec, er;
        cc = 3;
        cr = 0;
        repeat (100) begin
            cam1(0, 1, 0);
            if (bus.line_err || bus.frame_err || bus.locked) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL hunt_lsync_only got activity want none");
        end
        cam1(0, 0, 0);
        cam1(0, 0, 0);
        checks++;
        if ({bus.rx_col, bus.rx_row} !== {4'd6, 4'd3}) begin
            errors++;
            $display("FAIL verify_reload got %0d,%0d want 6,3",
                     bus.rx_col, bus.rx_row);
        end
        repeat (61) cam1(0, 0, 0);
        checks++;
        if (bus.locked !== 1'b0) begin
            errors++;
            $display("FAIL lock_early got %b want 0", bus.locked);
        end
        cam1(0, 0, 0);
        checks++;
        if (bus.locked !== 1'b1) begin
            errors++;
            $display("FAIL lock_rise got %b want 1", bus.locked);
        end
        for (int i = 0; i < 64; i++) begin
            ec = cc;
            er = cr;
            cam1(0, 0, 0);
            if (i == 0) begin
                checks++;
                if ({bus.sol, bus.sof} !== 2'b11) begin
                    errors++;
                    $display("FAIL first_sof got %b want 11",
                             {bus.sol, bus.sof});
                end
            end
            if (bus.rx_col != ec[AW-1:0] || bus.rx_row != er[AW-1:0])
                posbad = 1'b1;
            if (bus.sol) nsol++;
            if (bus.sof) begin
                nsof++;
                if (sof_t0 < 0) sof_t0 = tick;
                else sof_t1 = tick;
            end
        end
        checks++;
        if (nsol !== 8) begin
            errors++;
            $display("FAIL sol_count got %0d want 8", nsol);
        end
        checks++;
        if (nsof !== 2 || sof_t1 - sof_t0 !== 32) begin
            errors++;
            $display("FAIL sof_period got n=%0d d=%0d want n=2 d=32",
                     nsof, sof_t1 - sof_t0);
        end
        checks++;
        if (posbad !== 1'b0) begin
            errors++;
            $display("FAIL position_track got off want exact");
        end
        checks++;
        if (bus.err_cnt !== 16'd0) begin
            errors++;
            $display("FAIL clean_err_cnt got %0d want 0", bus.err_cnt);
        end
    endtask

    task automatic test_line_delay();
        run_to(7, 1);
        cam1(1, 0, 0);
        checks++;
        if (bus.line_err !== 1'b1) begin
            errors++;
            $display("FAIL lsync_missing got %b want 1", bus.line_err);
        end
        cam1(0, 0, 1);
        checks++;
        if ({bus.line_err, bus.frame_err} !== 2'b10) begin
            errors++;
            $display("FAIL lsync_spurious got %b want 10",
                     {bus.line_err, bus.frame_err});
        end
        checks++;
        if (bus.err_cnt !== 16'd2 || bus.locked !== 1'b1) begin
            errors++;
            $display("FAIL delay_status got cnt=%0d lk=%b want cnt=2 lk=1",
                     bus.err_cnt, bus.locked);
        end
        run_to(0, 0);
        cam1(0, 0, 0);
        run_to(0, 0);
        cam1(0, 0, 0);
        repeat (2) begin
            run_to(7, 3);
            cam1(0, 1, 0);
            checks++;
            if (bus.frame_err !== 1'b1) begin
                errors++;
                $display("FAIL fsync_drop2 got %b want 1", bus.frame_err);
            end
            run_to(0, 0);
            cam1(0, 0, 0);
        end
        checks++;
        if (bus.locked !== 1'b1) begin
            errors++;
            $display("FAIL bad_cleared got %b want 1", bus.locked);
        end
        run_to(0, 0);
        cam1(0, 0, 0);
        checks++;
        if (bus.err_cnt !== 16'd4) begin
            errors++;
            $display("FAIL delay_err_cnt got %0d want 4", bus.err_cnt);
        end
    endtask

    task automatic test_fsync_drop();
        for (int i = 0; i < 3; i++) begin
            run_to(7, 3);
            cam1(0, 1, 0);
            checks++;
            if (bus.frame_err !== 1'b1) begin
                errors++;
                $display("FAIL drop_frame_err got %b want 1", bus.frame_err);
            end
            run_to(0, 0);
            checks++;
            if (bus.locked !== 1'b1) begin
                errors++;
                $display("FAIL drop_pre_boundary got %b want 1", bus.locked);
            end
            cam1(0, 0, 0);
            if (i == 2) begin
                checks++;
                if (bus.locked !== 1'b0) begin
                    errors++;
                    $display("FAIL unlock got %b want 0", bus.locked);
                end
            end
        end
        repeat (63) cam1(0, 0, 0);
        checks++;
        if (bus.locked !== 1'b0) begin
            errors++;
            $display("FAIL relock_early got %b want 0", bus.locked);
        end
        cam1(0, 0, 0);
        checks++;
        if (bus.locked !== 1'b1 || bus.err_cnt !== 16'd7) begin
            errors++;
            $display("FAIL relock got lk=%b cnt=%0d want lk=1 cnt=7",
                     bus.locked, bus.err_cnt);
        end
    endtask

    task automatic test_verify_early();
        rst = 1'b1;
        cam1(0, 0, 0);
        rst = 1'b0;
        run_to(7, 3);
        cam1(0, 0, 0);
        run_to(0, 0);
        cam1(0, 0, 0);
        run_to(1, 1);
        cyc(1, 1);
        cc = 6;
        cr = 3;
        checks++;
        if ({bus.line_err, bus.frame_err} !== 2'b11) begin
            errors++;
            $display("FAIL early_errs got %b want 11",
                     {bus.line_err, bus.frame_err});
        end
        checks++;
        if (bus.err_cnt !== 16'd1 || bus.locked !== 1'b0) begin
            errors++;
            $display("FAIL early_status got cnt=%0d lk=%b want cnt=1 lk=0",
                     bus.err_cnt, bus.locked);
        end
        cam1(0, 0, 0);
        checks++;
        if ({bus.rx_col, bus.rx_row, bus.line_err} !== {4'd6, 4'd3, 1'b0}) begin
            errors++;
            $display("FAIL early_reload got %0d,%0d,%b want 6,3,0",
                     bus.rx_col, bus.rx_row, bus.line_err);
        end
        repeat (61) cam1(0, 0, 0);
        checks++;
        if (bus.locked !== 1'b0) begin
            errors++;
            $display("FAIL good_restart got %b want 0", bus.locked);
        end
        cam1(0, 0, 0);
        checks++;
        if (bus.locked !== 1'b1) begin
            errors++;
            $display("FAIL early_relock got %b want 1", bus.locked);
        end
    endtask

    task automatic test_reset_mid();
        bit seen = 1'b0;
        run_to(3, 2);
        rst = 1'b1;
        cam1(0, 0, 0);
        rst = 1'b0;
        checks++;
        if ({bus.rx_col, bus.rx_row} !== 8'd0) begin
            errors++;
            $display("FAIL mid_rst_pos got %0d,%0d want 0,0",
                     bus.rx_col, bus.rx_row);
        end
        checks++;
        if ({bus.sol, bus.sof, bus.locked, bus.line_err, bus.frame_err}
            !== 5'b0) begin
            errors++;
            $display("FAIL mid_rst_flags got %b want 00000",
                     {bus.sol, bus.sof, bus.locked,
                      bus.line_err, bus.frame_err});
        end
        checks++;
        if (bus.err_cnt !== 16'd0) begin
            errors++;
            $display("FAIL mid_rst_cnt got %0d want 0", bus.err_cnt);
        end
        repeat (64) begin
            cam1(0, 1, 0);
            if (bus.line_err || bus.frame_err || bus.locked ||
                bus.sol || bus.sof) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0 || bus.err_cnt !== 16'd0) begin
            errors++;
            $display("FAIL post_rst_hunt got seen=%b cnt=%0d want 0,0",
                     seen, bus.err_cnt);
        end
    endtask

    task automatic test_saturate();
        bit wrapped = 1'b0;
        logic [15:0] prev;
        run_to(7, 3);
        repeat (64) cam1(0, 0, 0);
        checks++;
        if (bus2.locked !== 1'b1 || bus2.err_cnt !== 16'd0) begin
            errors++;
            $display("FAIL sat_prelock got lk=%b cnt=%0d want 1,0",
                     bus2.locked, bus2.err_cnt);
        end
        prev = bus2.err_cnt;
        sat = 1'b1;
        repeat (70000) begin
            cam1(0, 0, 0);
            if (bus2.err_cnt < prev) wrapped = 1'b1;
            prev = bus2.err_cnt;
        end
        sat = 1'b0;
        checks++;
        if (bus2.err_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL sat_value got %0h want ffff", bus2.err_cnt);
        end
        checks++;
        if (wrapped !== 1'b0 || bus2.locked !== 1'b1) begin
            errors++;
            $display("FAIL sat_nowrap got wrap=%b lk=%b want 0,1",
                     wrapped, bus2.locked);
        end
        checks++;
        if (bus.err_cnt !== 16'd0 || bus.locked !== 1'b1) begin
            errors++;
            $display("FAIL main_quiet got cnt=%0d lk=%b want 0,1",
                     bus.err_cnt, bus.locked);
        end
    endtask

    initial begin
        bus.lsync_in  = 1'b0;
        bus.fsync_in  = 1'b0;
        bus2.lsync_in = 1'b0;
        bus2.fsync_in = 1'b0;
        test_reset();
        test_lock();
        test_line_delay();
        test_fsync_drop();
        test_verify_early();
        test_reset_mid();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
